ln_unit: RTL and testbench

Iterative natural-log unit, the inverse of the attention engine's exp stage. It maps an unsigned Q2.6 magnitude, such as a softmax denominator or an exp output, to ln(x) in signed Q3.5. This lets the engine use log-domain softmax (x - ln(sum)). It uses a multi-cycle normalise/correct/scale FSM with valid/ready on both sides, and sits between the row-sum accumulator and the subtract stage.

---
 rtl/ln_unit.sv | 148 ++++++++++++++
 tb/tb_ln_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ln_unit.sv
// Iterative natural log: unsigned Q2.6 magnitude in, signed Q3.5 ln(x) out, via normalise/correct/scale.
// Define LN_ROUND_EN to round the final scale half-up instead of flooring it.
module ln_unit #(
    parameter int LN2_Q8 = 177,
    parameter int CORR_K = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_x,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] ln_out,
    output logic       out_sat,
    output logic       out_zero
);

    typedef enum logic [2:0] {IDLE, NORM, CORR, SCALE, DONE} state_t;

    localparam logic signed [18:0] LN2_S = 19'(LN2_Q8);

    state_t             state_q, state_d;
    logic [7:0]         m_q, m_d;
    logic signed [3:0]  k_q, k_d;
    logic signed [10:0] l2_q, l2_d;
    logic [7:0]         ln_q, ln_d;
    logic               sat_q, sat_d;
    logic               zero_q, zero_d;
    logic               vld_q, vld_d;

    logic [6:0]         f;
    logic [7:0]         f_inv;
    logic [14:0]        corr_prod;
    logic [7:0]         corr;
    logic [11:0]        c2_prod;
    logic [6:0]         c2;
    logic signed [10:0] l2_calc;
    logic signed [18:0] p, p_adj, v;

    function automatic logic [8:0] sat8(input logic signed [18:0] val);
        if (val < -19'sd128)
            sat8 = {1'b1, 8'h80};
        else if (val > 19'sd127)
            sat8 = {1'b1, 8'h7F};
        else
            sat8 = {1'b0, val[7:0]};
    endfunction

    // Quadratic correction of the linear mantissa approximation to log2(1+f)
    always_comb begin
        f         = m_q[6:0];
        f_inv     = 8'd128 - {1'b0, f};
        corr_prod = 15'(f) * 15'(f_inv);
        corr      = 8'(corr_prod >> 7);
        c2_prod   = 12'(corr) * 12'(CORR_K);
        c2        = 7'(c2_prod >> 5);
        l2_calc   = $signed({k_q, 7'd0}) + $signed({4'd0, f}) + $signed({4'd0, c2});
        p         = $signed({{8{l2_q[10]}}, l2_q}) * LN2_S;
`ifdef LN_ROUND_EN
        p_adj     = p + 19'sd512;
`else
        p_adj     = p;
`endif
        v         = p_adj >>> 10;
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        k_d     = k_q;
        l2_d    = l2_q;
        ln_d    = ln_q;
        sat_d   = sat_q;
        zero_d  = zero_q;
        vld_d   = vld_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = in_x;
                    k_d     = 4'sd1;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (m_q == 8'd0) begin
                    ln_d    = 8'h80;
                    zero_d  = 1'b1;
                    sat_d   = 1'b0;
                    state_d = DONE;
                end else if (m_q[7]) begin
                    state_d = CORR;
                end else begin
                    m_d = {m_q[6:0], 1'b0};
                    k_d = k_q - 4'sd1;
                end
            end
            CORR: begin
                l2_d    = l2_calc;
                state_d = SCALE;
            end
            SCALE: begin
                {sat_d, ln_d} = sat8(v);
                zero_d        = 1'b0;
                state_d       = DONE;
            end
            DONE: begin
                // out_valid rises one cycle after entering DONE and drops on the handshake
                if (vld_q && out_ready) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    vld_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ln_q    <= 8'd0;
            sat_q   <= 1'b0;
            zero_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ln_q    <= ln_d;
            sat_q   <= sat_d;
            zero_q  <= zero_d;
            vld_q   <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        m_q  <= m_d;
        k_q  <= k_d;
        l2_q <= l2_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = vld_q;
    assign ln_out    = ln_q;
    assign out_sat   = sat_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_ln_unit.sv
// Directed self-checking bench for ln_unit with hand-computed Q3.5 results.
module tb_ln_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] ln_out;
    logic       out_sat;
    logic       out_zero;

    int n_cmp = 0;
    int n_bad = 0;

    ln_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ln_out    (ln_out),
        .out_sat   (out_sat),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand, wait for the result, check it, let the handshake complete.
    task automatic do_op(input string tag, input logic [7:0] x, input logic [7:0] exp_ln,
                         input logic exp_sat, input logic exp_zero, input int exp_lat);
        int  n;
        logic got;
        out_ready = 1'b1;
        in_x      = x;
        in_valid  = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            tick();
            n++;
            got = out_valid;
        end
        check({tag, "_valid"}, 32'(got), 32'd1);
        if (exp_lat > 0) check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_ln"}, 32'(ln_out), 32'(exp_ln));
        check({tag, "_sat"}, 32'(out_sat), 32'(exp_sat));
        check({tag, "_zero"}, 32'(out_zero), 32'(exp_zero));
        tick();
        check({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int   n;
        logic seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = 8'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ln", 32'(ln_out), 32'd0);
        check("rst_sat", 32'(out_sat), 32'd0);
        check("rst_zero", 32'(out_zero), 32'd0);
        rst_n = 1'b1;
        tick();

        do_op("x64", 8'd64, 8'd0, 1'b0, 1'b0, 5);
        do_op("x128", 8'd128, 8'd22, 1'b0, 1'b0, 4);
`ifdef LN_ROUND_EN
        do_op("x96", 8'd96, 8'd13, 1'b0, 1'b0, 5);
        do_op("x32", 8'd32, 8'(-22), 1'b0, 1'b0, 6);
        do_op("x48", 8'd48, 8'(-9), 1'b0, 1'b0, 6);
`else
        do_op("x96", 8'd96, 8'd12, 1'b0, 1'b0, 5);
        do_op("x32", 8'd32, 8'(-23), 1'b0, 1'b0, 6);
        do_op("x48", 8'd48, 8'(-10), 1'b0, 1'b0, 6);
`endif
        do_op("x200", 8'd200, 8'd36, 1'b0, 1'b0, 4);
        do_op("x1", 8'd1, 8'h80, 1'b1, 1'b0, 0);
        do_op("x0", 8'd0, 8'h80, 1'b0, 1'b1, 2);

        // Backpressure with in_valid held high (operand 0) while busy
        out_ready = 1'b0;
        in_x      = 8'd255;
        in_valid  = 1'b1;
        tick();
        in_x = 8'd0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            tick();
            n++;
            seen = out_valid;
            if (!seen) check("bp_busy_ready", 32'(in_ready), 32'd0);
        end
        check("bp_latency", 32'(n), 32'd4);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_ln", 32'(ln_out), 32'd44);
            check("bp_hold_ready", 32'(in_ready), 32'd0);
            tick();
        end
        check("bp_sat", 32'(out_sat), 32'd0);
        check("bp_zero", 32'(out_zero), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_vld_drop", 32'(out_valid), 32'd0);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (4) begin
            tick();
            seen = seen | out_valid;
        end
        check("bp_no_extra_op", 32'(seen), 32'd0);

        // Reset while normalising discards the operation
        in_x     = 8'd2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ln", 32'(ln_out), 32'd0);
        check("mid_rst_sat", 32'(out_sat), 32'd0);
        check("mid_rst_zero", 32'(out_zero), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (15) begin
            tick();
            seen = seen | out_valid;
        end
        check("mid_rst_no_result", 32'(seen), 32'd0);
        check("mid_rst_ready_after", 32'(in_ready), 32'd1);

        do_op("x255_after_rst", 8'd255, 8'd44, 1'b0, 1'b0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
